ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter for the mouse port: serialises one command byte (reset, enable reporting, set sample rate, IntelliMouse wheel-enable sequence) onto the open-drain clock/data lines. It performs inhibit, request-to-send, bit shifting on device clock edges and acknowledge checking. It sits beside the mouse receiver under the mouse master state machine, which issues commands and waits for BYTE_SENT or ERROR.

---
 rtl/ps2_pkg.sv | 15 +
 rtl/ps2_line_sync.sv | 29 ++
 rtl/ps2_host_tx.sv | 135 +++++++++++++
 tb/tb_ps2_host_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types, error codes and mouse command bytes.
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, WAIT_IDLE, ERR} state_e;
    localparam logic [1:0] ERR_START = 2'b01;
    localparam logic [1:0] ERR_XFER  = 2'b10;
    localparam logic [1:0] ERR_NOACK = 2'b11;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_GET_ID   = 8'hF2;
    localparam logic [7:0] CMD_SET_RES  = 8'hE8;
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchroniser and falling-edge detect for one PS/2 line.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic sync,
    output logic fall
);
    logic meta_q, meta_d, sync_q, sync_d, prev_q, prev_d;
    always_comb begin
        meta_d = line_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end
    // Idle PS/2 lines float high, so reset to 1 to avoid a spurious fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end
    assign sync = sync_q;
    assign fall = prev_q & ~sync_q;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter with inhibit, request-to-send,
// device-clocked shifting, acknowledge check and start/transfer timeouts.
module ps2_host_tx import ps2_pkg::*; #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int START_TIMEOUT  = 1500000,
    parameter int XFER_TIMEOUT   = 200000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    output logic       CLK_MOUSE_OUT_EN,
    output logic       DATA_MOUSE_OUT_EN,
    input  logic       SEND_BYTE,
    input  logic [7:0] BYTE_TO_SEND,
    output logic       BUSY,
    output logic       BYTE_SENT,
    output logic       ERROR,
    output logic [1:0] ERR_CODE
);
    state_e      state_q, state_d;
    logic [9:0]  frame_q, frame_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [20:0] cnt_q, cnt_d, cnt_inc;
    logic        clk_en_q, clk_en_d, data_en_q, data_en_d, sent_q, sent_d;
    logic [1:0]  code_q, code_d, fail;
    logic        clk_sync, clk_fall, data_sync, data_fall_unused;

    ps2_line_sync u_clk_sync (.clk(CLK), .rst_n(RESET), .line_in(CLK_MOUSE_IN), .sync(clk_sync), .fall(clk_fall));
    ps2_line_sync u_data_sync (.clk(CLK), .rst_n(RESET), .line_in(DATA_MOUSE_IN), .sync(data_sync), .fall(data_fall_unused));

    always_comb begin
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 21'd1;
        state_d   = state_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        cnt_d     = cnt_inc;
        clk_en_d  = clk_en_q;
        data_en_d = data_en_q;
        sent_d    = 1'b0;
        code_d    = code_q;
        fail      = 2'b00;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (SEND_BYTE) begin
                    frame_d  = {1'b1, odd_parity(BYTE_TO_SEND), BYTE_TO_SEND};
                    clk_en_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q >= 21'(INHIBIT_CYCLES)) begin
                    clk_en_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = REQ;
                end else if (cnt_q >= 21'(INHIBIT_CYCLES - 1)) begin
                    data_en_d = 1'b1;
                end
            end
            REQ: begin
                if (clk_fall) begin
                    data_en_d = ~frame_q[0];
                    frame_d   = {1'b0, frame_q[9:1]};
                    bit_cnt_d = 4'd1;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end else if (cnt_inc >= 21'(START_TIMEOUT)) begin
                    fail = ERR_START;
                end
            end
            SHIFT: begin
                // Edges 1..10 carry data, parity and stop; edge 11 is the device ack.
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd10) begin
                        data_en_d = ~frame_q[0];
                        frame_d   = {1'b0, frame_q[9:1]};
                    end else if (data_sync) begin
                        fail = ERR_NOACK;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end else if (cnt_inc >= 21'(XFER_TIMEOUT)) begin
                    fail = ERR_XFER;
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    sent_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_inc >= 21'(XFER_TIMEOUT)) begin
                    fail = ERR_XFER;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fail != 2'b00) begin
            state_d   = ERR;
            code_d    = fail;
            clk_en_d  = 1'b0;
            data_en_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            bit_cnt_q <= '0;
            cnt_q     <= '0;
            clk_en_q  <= 1'b0;
            data_en_q <= 1'b0;
            sent_q    <= 1'b0;
            code_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            cnt_q     <= cnt_d;
            clk_en_q  <= clk_en_d;
            data_en_q <= data_en_d;
            sent_q    <= sent_d;
            code_q    <= code_d;
        end
    end

    assign CLK_MOUSE_OUT_EN  = clk_en_q;
    assign DATA_MOUSE_OUT_EN = data_en_q;
    assign BUSY              = (state_q != IDLE);
    assign BYTE_SENT         = sent_q;
    assign ERROR             = (state_q == ERR);
    assign ERR_CODE          = code_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench with an open-drain PS/2 device model and a
// frame-level reference model for ps2_host_tx.
module tb_ps2_host_tx;
    import ps2_pkg::*;
    localparam int INH = 20, STO = 200, XTO = 2000, HALF = 20, PER = 10;

    logic clk = 1'b0, rst_n = 1'b0;
    logic dev_clk = 1'b1, dev_data = 1'b1;
    logic send = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic clk_oe, data_oe, busy, sent, err;
    logic [1:0] code;
    logic clk_line, data_line;
    int tests = 0, fails = 0;
    int sent_cnt = 0, err_cnt = 0;
    int dev_edges = 11, dev_edge_no = 0;
    bit dev_ack = 1'b1;
    logic [10:0] dev_bits = '0;
    time t_fall = 0;

    assign clk_line  = dev_clk & ~clk_oe;
    assign data_line = dev_data & ~data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(STO), .XFER_TIMEOUT(XTO)) dut (
        .CLK(clk), .RESET(rst_n), .CLK_MOUSE_IN(clk_line), .DATA_MOUSE_IN(data_line),
        .CLK_MOUSE_OUT_EN(clk_oe), .DATA_MOUSE_OUT_EN(data_oe),
        .SEND_BYTE(send), .BYTE_TO_SEND(byte_in),
        .BUSY(busy), .BYTE_SENT(sent), .ERROR(err), .ERR_CODE(code)
    );

    always #(PER / 2) clk = ~clk;

    always @(negedge clk) begin
        if (sent) sent_cnt++;
        if (err) err_cnt++;
    end

    initial begin
        #(PER * 90000);
        $display("FAIL watchdog: simulation still running, required finish before %0d cycles", 90000);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame as the device sees it: start, D0..D7, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic p;
        p = ($countones(b) % 2 == 0);
        return {1'b1, p, b, 1'b0};
    endfunction

    // Device: answers a request-to-send by clocking dev_edges edges, sampling on rising edges.
    initial begin
        int n;
        forever begin
            @(negedge clk);
            if (rst_n && !clk_oe && data_oe && dev_edges > 0) begin
                repeat ($urandom_range(4, 30)) @(negedge clk);
                dev_bits[0] = data_line;
                for (int i = 1; i <= dev_edges; i++) begin
                    dev_clk = 1'b0;
                    if (i == 1) t_fall = $time;
                    dev_edge_no = i;
                    repeat (HALF) @(negedge clk);
                    if (i <= 10) dev_bits[i] = data_line;
                    dev_clk = 1'b1;
                    if (i == 10 && dev_ack) dev_data = 1'b0;
                    if (i == 11) dev_data = 1'b1;
                    if (i < 11) repeat (HALF) @(negedge clk);
                end
                n = 0;
                while (dev_edges < 11 && busy && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
            end
        end
    end

    task automatic send_cmd(input logic [7:0] b);
        send = 1'b1;
        byte_in = b;
        @(negedge clk);
        send = 1'b0;
    endtask

    task automatic check_inhibit();
        int n = 0;
        while (clk_oe && !data_oe && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", n, INH);
        check("start_bit_clk_low", {clk_oe, data_oe}, 2'b11);
        n = 0;
        while (clk_oe && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("start_bit_cycles", n, 1);
        check("req_lines", {clk_oe, data_oe}, 2'b01);
    endtask

    task automatic wait_edge(input int k);
        int n = 0;
        while (dev_edge_no < k && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("edge_reached", dev_edge_no >= k, 1);
    endtask

    task automatic wait_done(output bit s, output bit e, output logic ba, output logic [1:0] cd,
                             output logic [1:0] oe, output time t);
        int n = 0;
        while (!(sent || err) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", (sent || err), 1);
        s = sent;
        e = err;
        ba = busy;
        cd = code;
        oe = {clk_oe, data_oe};
        t = $time;
    endtask

    task automatic xfer(input logic [7:0] b, input int edges, input bit ack, input int poke,
                        output bit s, output bit e, output logic ba, output logic [1:0] cd,
                        output logic [1:0] oe, output time tr, output time td);
        dev_edges = edges;
        dev_ack = ack;
        dev_edge_no = 0;
        send_cmd(b);
        check("busy_after_req", busy, 1);
        check_inhibit();
        tr = $time;
        fork
            begin
                if (poke > 0) begin
                    wait_edge(poke);
                    send = 1'b1;
                    byte_in = 8'h12;
                    @(negedge clk);
                    send = 1'b0;
                end
            end
            wait_done(s, e, ba, cd, oe, td);
        join
    endtask

    initial begin
        bit s, e;
        logic ba;
        logic [1:0] cd, oe;
        time tr, td;
        int sc, ec, d;
        logic [7:0] b;
        repeat (3) @(negedge clk);
        check("reset_outputs", {clk_oe, data_oe, busy, sent, err, code}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        sc = sent_cnt; ec = err_cnt;
        xfer(CMD_ENABLE, 11, 1'b1, 0, s, e, ba, cd, oe, tr, td);
        check("t1_sent", s, 1);
        check("t1_busy_at_sent", ba, 0);
        check("t1_start", dev_bits[0], 0);
        check("t1_data", dev_bits[8:1], 8'hF4);
        check("t1_parity", dev_bits[9], 0);
        check("t1_stop", dev_bits[10], 1);
        repeat (40) @(negedge clk);
        check("t1_sent_pulses", sent_cnt - sc, 1);
        check("t1_err_pulses", err_cnt - ec, 0);
        check("t1_lines_idle", {clk_oe, data_oe, busy}, 0);

        sc = sent_cnt;
        xfer(8'hFF, 11, 1'b1, 0, s, e, ba, cd, oe, tr, td);
        check("t2a_sent", s, 1);
        check("t2a_frame", dev_bits, frame_of(8'hFF));
        check("t2a_parity", dev_bits[9], 1);
        xfer(8'h00, 11, 1'b1, 0, s, e, ba, cd, oe, tr, td);
        check("t2b_sent", s, 1);
        check("t2b_frame", dev_bits, frame_of(8'h00));
        check("t2b_parity", dev_bits[9], 1);
        repeat (40) @(negedge clk);
        check("t2_sent_pulses", sent_cnt - sc, 2);

        xfer(CMD_RESET, 0, 1'b1, 0, s, e, ba, cd, oe, tr, td);
        check("t3_error", e, 1);
        check("t3_code", cd, ERR_START);
        check("t3_delay", int'((td - tr) / PER), STO);
        check("t3_lines", oe, 2'b00);
        repeat (40) @(negedge clk);

        sc = sent_cnt; ec = err_cnt;
        xfer(CMD_SET_RATE, 11, 1'b0, 0, s, e, ba, cd, oe, tr, td);
        check("t4_error", e, 1);
        check("t4_code", cd, ERR_NOACK);
        repeat (40) @(negedge clk);
        check("t4_no_sent", sent_cnt - sc, 0);
        check("t4_err_pulses", err_cnt - ec, 1);

        xfer(CMD_GET_ID, 5, 1'b1, 0, s, e, ba, cd, oe, tr, td);
        d = int'((td - t_fall) / PER);
        check("t5_error", e, 1);
        check("t5_code", cd, ERR_XFER);
        check("t5_delay_window", (d >= XTO && d <= XTO + 4), 1);
        check("t5_lines", oe, 2'b00);
        repeat (40) @(negedge clk);
        check("t5_code_held", code, ERR_XFER);

        ec = err_cnt;
        dev_edges = 6; dev_ack = 1'b1; dev_edge_no = 0;
        send_cmd(8'hC8);
        check_inhibit();
        fork
            begin
                wait_edge(3);
                send = 1'b1;
                byte_in = 8'h12;
                @(negedge clk);
                send = 1'b0;
            end
            begin
                wait_edge(6);
                repeat (4) @(negedge clk);
                check("t6_data_low_before_rst", data_oe, 1);
                #2 rst_n = 1'b0;
                #1;
                check("t6_rst_lines", {clk_oe, data_oe}, 2'b00);
                check("t6_rst_busy", busy, 0);
            end
        join
        check("t6_partial_bits", dev_bits[5:1], 5'b01000);
        repeat (3) @(negedge clk);
        check("t6_rst_outputs", {sent, err, code}, 0);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("t6_no_err_pulse", err_cnt - ec, 0);
        xfer(CMD_ENABLE, 11, 1'b1, 0, s, e, ba, cd, oe, tr, td);
        check("t6_after_rst_sent", s, 1);
        check("t6_after_rst_frame", dev_bits, frame_of(CMD_ENABLE));
        repeat (40) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            sc = sent_cnt;
            xfer(b, 11, 1'b1, $urandom_range(2, 9), s, e, ba, cd, oe, tr, td);
            check("rnd_sent", s, 1);
            check("rnd_no_err", e, 0);
            check("rnd_frame", dev_bits, frame_of(b));
            repeat (40) @(negedge clk);
            check("rnd_not_queued", busy, 0);
            check("rnd_sent_pulses", sent_cnt - sc, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
